// File: rtl/vga_pic_edge.sv
// -----------------------------------------------------------------------------
// vga_pic_edge
// Frame-buffer picture source sitting in front of the VGA timing controller.
// A raster-ordered 8-bit pixel stream from the edge-detection pipeline is stored
// as one IMG_W x IMG_H image in on-chip RAM. The controller's pix_x/pix_y
// requests are answered one cycle later. The stored image appears at
// (H_POS,V_POS) on a BG_COLOR background.
//
// Ports
//   vga_clk      in   1   single clock for write and read sides
//   sys_rst_n    in   1   asynchronous active-low reset
//   wr_en        in   1   write-stream pixel valid
//   wr_sof       in   1   start of frame, qualifies the first pixel of a frame
//   wr_data      in   8   write-stream pixel value
//   pix_x        in  10   requested column, 10'h3ff = no request
//   pix_y        in  10   requested row,    10'h3ff = no request
//   pix_data     out  8   pixel for the (pix_x,pix_y) of the previous cycle
//   frame_valid  out  1   sticky, set once a complete frame has been written
//   frame_done   out  1   one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module vga_pic_edge #(
    parameter int         IMG_W    = 100,
    parameter int         IMG_H    = 100,
    parameter int         H_POS    = 270,
    parameter int         V_POS    = 190,
    parameter logic [7:0] BG_COLOR = 8'h00,
    parameter int         ADDR_W   = 14
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       wr_en,
    input  logic       wr_sof,
    input  logic [7:0] wr_data,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [7:0] pix_data,
    output logic       frame_valid,
    output logic       frame_done
);

    localparam int                DEPTH     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
    localparam logic [9:0]        X_LO      = 10'(H_POS);
    localparam logic [9:0]        X_HI      = 10'(H_POS + IMG_W - 1);
    localparam logic [9:0]        Y_LO      = 10'(V_POS);
    localparam logic [9:0]        Y_HI      = 10'(V_POS + IMG_H - 1);
    localparam logic [9:0]        NO_REQ    = 10'h3ff;

    logic [7:0]        ram [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_last;
    logic              in_win;
    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        ram_q;
    logic              sel_q;

    // A pixel flagged with wr_sof always lands at address 0, so an early
    // start-of-frame silently restarts the image.
    always_comb begin
        wr_ptr  = wr_sof ? '0 : wr_addr;
        wr_last = wr_en && (wr_ptr == LAST_ADDR);
    end

    // Write pointer and frame status. frame_done is registered, so it pulses
    // the cycle after the last pixel is written; a restarted partial frame
    // never reaches LAST_ADDR and so produces no pulse.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_addr     <= '0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= wr_last;
            if (wr_last) begin
                frame_valid <= 1'b1;
            end
            if (wr_en) begin
                wr_addr <= wr_last ? '0 : wr_ptr + ADDR_W'(1);
            end else if (wr_sof) begin
                wr_addr <= '0;
            end
        end
    end

    // Window test and address translation. The 3ff "no request" code is
    // rejected explicitly so it stays outside even for windows near the edge.
    // Outside the window the address is parked at 0 to keep reads in range.
    always_comb begin
        in_win  = (pix_x != NO_REQ) && (pix_y != NO_REQ) &&
                  (pix_x >= X_LO) && (pix_x <= X_HI) &&
                  (pix_y >= Y_LO) && (pix_y <= Y_HI);
        dx      = pix_x - X_LO;
        dy      = pix_y - Y_LO;
        rd_addr = in_win ? (ADDR_W'(dy) * IMG_W_A + ADDR_W'(dx)) : '0;
    end

    // Simple dual-port RAM, no reset. Both accesses use non-blocking
    // assignment, so a same-address read and write returns the old contents.
    always_ff @(posedge vga_clk) begin
        if (wr_en) begin
            ram[wr_ptr] <= wr_data;
        end
        ram_q <= ram[rd_addr];
    end

    // The window/valid decision is registered alongside the RAM read so the
    // output mux sees both from the same request.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= in_win && frame_valid;
        end
    end

    // While sel_q is clear (including reset) the output shows the background.
    assign pix_data = sel_q ? ram_q : BG_COLOR;

endmodule

// File: tb/tb_vga_pic_edge.sv
// -----------------------------------------------------------------------------
// tb_vga_pic_edge
// Self-checking bench for vga_pic_edge. A behavioural frame-buffer model
// predicts every pix_data; predictions are queued when a request is driven and
// popped when the DUT answers one cycle later. Table vectors carry hand-derived
// constants for the window corners and known pixel values.
// -----------------------------------------------------------------------------
module tb_vga_pic_edge;

    localparam int         IMG_W    = 100;
    localparam int         IMG_H    = 100;
    localparam int         H_POS    = 270;
    localparam int         V_POS    = 190;
    localparam logic [7:0] BG_COLOR = 8'h00;
    localparam int         ADDR_W   = 14;
    localparam int         DEPTH    = IMG_W * IMG_H;

    typedef struct {
        int         px;
        int         py;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic       vga_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       wr_en     = 1'b0;
    logic       wr_sof    = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic [9:0] pix_x     = 10'h3ff;
    logic [9:0] pix_y     = 10'h3ff;
    logic [7:0] pix_data;
    logic       frame_valid;
    logic       frame_done;

    vga_pic_edge #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .H_POS    (H_POS),
        .V_POS    (V_POS),
        .BG_COLOR (BG_COLOR),
        .ADDR_W   (ADDR_W)
    ) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .wr_en       (wr_en),
        .wr_sof      (wr_sof),
        .wr_data     (wr_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .frame_valid (frame_valid),
        .frame_done  (frame_done)
    );

    always #5 vga_clk = ~vga_clk;

    int         errors   = 0;
    int         checks   = 0;
    int         done_cnt = 0;
    logic [7:0] mem [DEPTH];
    int         m_wr_addr = 0;
    logic       m_valid   = 1'b0;
    logic [7:0] sb [$];

    // Reference picture lookup using plain integer arithmetic.
    function automatic logic [7:0] modelPix(input int x, input int y);
        if (m_valid && x >= H_POS && x < H_POS + IMG_W &&
            y >= V_POS && y < V_POS + IMG_H) begin
            return mem[(y - V_POS) * IMG_W + (x - H_POS)];
        end
        return BG_COLOR;
    endfunction

    function automatic logic [7:0] patData(input int kind, input int a);
        case (kind)
            0:       return 8'(a);
            1:       return 8'(a * 3 + 7);
            default: return 8'(a) ^ 8'h5A;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: drive, predict, advance, compare.
    task automatic applyStimulus(input logic en, input logic sof, input logic [7:0] data,
                                 input int x, input int y, input bit use_given,
                                 input logic [7:0] given, input string tag);
        logic [7:0] exp_pix;
        int         waddr;
        bit         exp_done;
        wr_en   = en;
        wr_sof  = sof;
        wr_data = data;
        pix_x   = 10'(x);
        pix_y   = 10'(y);
        exp_pix = use_given ? given : modelPix(x, y);
        sb.push_back(exp_pix);
        exp_done = 1'b0;
        if (en) begin
            waddr      = sof ? 0 : m_wr_addr;
            mem[waddr] = data;
            if (waddr == DEPTH - 1) begin
                exp_done  = 1'b1;
                m_valid   = 1'b1;
                m_wr_addr = 0;
            end else begin
                m_wr_addr = waddr + 1;
            end
        end else if (sof) begin
            m_wr_addr = 0;
        end
        @(posedge vga_clk);
        #1;
        checkOutput({"pix_data ", tag}, 32'(pix_data), 32'(sb.pop_front()));
        checkOutput("frame_done", 32'(frame_done), 32'(exp_done));
        checkOutput("frame_valid", 32'(frame_valid), 32'(m_valid));
        if (frame_done === 1'b1) done_cnt++;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1023, 1023, 1'b0, 8'h00, "idle");
    endtask

    // Streams count pixels while reading back the row being written.
    task automatic writeFrame(input int kind, input int count, input bit first_sof);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, first_sof && (i == 0), patData(kind, i),
                          H_POS + (i % IMG_W), V_POS + ((i / IMG_W) % IMG_H),
                          1'b0, 8'h00, "wr");
        end
    endtask

    task automatic runTable(input vec_t v[]);
        for (int i = 0; i < v.size(); i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, v[i].px, v[i].py, 1'b1, v[i].exp, v[i].name);
        end
    endtask

    initial begin
        vec_t t3[];
        vec_t t5[];
        t3 = new[12];
        t3[0]  = '{H_POS + 5,  V_POS + 2,  8'hCD, "addr205"};
        t3[1]  = '{H_POS - 1,  V_POS,      8'h00, "left_of_win"};
        t3[2]  = '{1023,       1023,       8'h00, "no_request"};
        t3[3]  = '{H_POS,      V_POS,      8'h00, "corner_tl"};
        t3[4]  = '{H_POS + 99, V_POS,      8'h63, "corner_tr"};
        t3[5]  = '{H_POS,      V_POS + 99, 8'hAC, "corner_bl"};
        t3[6]  = '{H_POS + 99, V_POS + 99, 8'h0F, "corner_br"};
        t3[7]  = '{H_POS + 3,  V_POS + 1,  8'h67, "addr103"};
        t3[8]  = '{H_POS + 100, V_POS,     8'h00, "right_of_win"};
        t3[9]  = '{H_POS,      V_POS + 100, 8'h00, "below_win"};
        t3[10] = '{H_POS + 99, V_POS - 1,  8'h00, "above_win"};
        t3[11] = '{H_POS,      1023,       8'h00, "y_no_request"};
        t5 = new[3];
        t5[0] = '{H_POS + 10, V_POS, 8'h25, "f2_addr10"};
        t5[1] = '{H_POS + 49, V_POS, 8'h9A, "f2_addr49"};
        t5[2] = '{H_POS + 50, V_POS, 8'h9D, "f2_addr50"};

        // Reset state
        repeat (2) @(posedge vga_clk);
        #1;
        checkOutput("reset pix_data", 32'(pix_data), 32'h00);
        checkOutput("reset frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset frame_done", 32'(frame_done), 32'h0);
        sys_rst_n = 1'b1;

        // No frame yet: window request gives background
        applyStimulus(1'b0, 1'b0, 8'h00, H_POS, V_POS, 1'b1, BG_COLOR, "t1_no_frame");

        // First full frame, data = addr[7:0]
        done_cnt = 0;
        writeFrame(0, DEPTH, 1'b1);
        idle();
        checkOutput("t2 frame_done pulses", 32'(done_cnt), 32'd1);

        // Known pixels and window boundaries
        runTable(t3);

        // Sub-sampled 800x525 raster against the model
        for (int y = 0; y < 525; y += 3) begin
            for (int x = 0; x < 800; x += 5) begin
                applyStimulus(1'b0, 1'b0, 8'h00, x, y, 1'b0, 8'h00, "sweep");
            end
        end

        // Partial frame, bare start-of-frame, then a full frame without sof
        done_cnt = 0;
        writeFrame(2, 50, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1023, 1023, 1'b0, 8'h00, "sof_only");
        writeFrame(1, DEPTH, 1'b0);
        idle();
        checkOutput("t5 frame_done pulses", 32'(done_cnt), 32'd1);
        runTable(t5);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, H_POS + i, V_POS, 1'b0, 8'h00, "f2_row0");
        end

        // Same-address read and write: old value first, new value after
        writeFrame(1, 200, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'hEE, H_POS, V_POS + 2, 1'b1, 8'h5F, "rw_old");
        applyStimulus(1'b0, 1'b0, 8'h00, H_POS, V_POS + 2, 1'b1, 8'hEE, "rw_new");

        // Reset in the middle of a write burst
        writeFrame(0, 30, 1'b1);
        wr_en     = 1'b1;
        wr_data   = 8'h77;
        sys_rst_n = 1'b0;
        #2;
        checkOutput("midreset pix_data", 32'(pix_data), 32'h00);
        checkOutput("midreset frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("midreset frame_done", 32'(frame_done), 32'h0);
        sb.delete();
        m_wr_addr = 0;
        m_valid   = 1'b0;
        wr_en     = 1'b0;
        sys_rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, H_POS, V_POS + 2, 1'b1, BG_COLOR, "post_reset_bg");

        // Frame without sof must start from address 0 after reset
        done_cnt = 0;
        writeFrame(1, DEPTH, 1'b0);
        idle();
        checkOutput("post_reset frame_done pulses", 32'(done_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, H_POS, V_POS, 1'b1, 8'h07, "post_reset_addr0");
        applyStimulus(1'b0, 1'b0, 8'h00, H_POS + 99, V_POS + 99, 1'b1, 8'h34, "post_reset_last");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
